// File: rtl/itype_pkg.sv
// Shared definitions for the integer execute/write-back slice: widths,
// opcode constants, main-control ALU classes and internal ALU functions.
package itype_pkg;

  localparam int unsigned XLEN  = 64;
  localparam int unsigned NREGS = 32;
  localparam int unsigned AW    = $clog2(NREGS);

  localparam logic [6:0] OP_REG  = 7'b0110011;
  localparam logic [6:0] OP_IMM  = 7'b0010011;
  localparam logic [6:0] OP_LOAD = 7'b0000011;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10,
    ALUOP_RSVD  = 2'b11
  } alu_op_e;

  typedef enum logic [3:0] {
    FN_ADD,
    FN_SUB,
    FN_SLL,
    FN_SLT,
    FN_SLTU,
    FN_XOR,
    FN_SRL,
    FN_SRA,
    FN_OR,
    FN_AND
  } alu_fn_e;

  // I-type and load instructions take their second operand from the immediate.
  function automatic logic uses_imm(input logic [6:0] opcode);
    return (opcode == OP_IMM) || (opcode == OP_LOAD);
  endfunction

  function automatic logic [XLEN-1:0] sext_imm12(input logic [11:0] imm);
    return {{(XLEN-12){imm[11]}}, imm};
  endfunction

endpackage

// File: rtl/itype_regfile.sv
// 32x64 register file: two combinational read ports, one synchronous write
// port, synchronous reset to index values, x0 hardwired to zero.
// ITYPE_DBG_PORT_EN adds a third combinational debug read port.
module itype_regfile
  import itype_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   i_raddr_a,
  input  logic [AW-1:0]   i_raddr_b,
  output logic [XLEN-1:0] o_rdata_a,
  output logic [XLEN-1:0] o_rdata_b,
`ifdef ITYPE_DBG_PORT_EN
  input  logic [AW-1:0]   i_raddr_dbg,
  output logic [XLEN-1:0] o_rdata_dbg,
`endif
  input  logic            i_we,
  input  logic [AW-1:0]   i_waddr,
  input  logic [XLEN-1:0] i_wdata
);

  logic [XLEN-1:0] r_regs [0:NREGS-1];
  logic            w_wr_en;

  assign w_wr_en = i_we && (i_waddr != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        r_regs[i] <= XLEN'(i);
      end
    end else if (w_wr_en) begin
      r_regs[i_waddr] <= i_wdata;
    end
  end

  // x0 is forced at the read mux so a stray write can never surface.
  assign o_rdata_a = (i_raddr_a == '0) ? '0 : r_regs[i_raddr_a];
  assign o_rdata_b = (i_raddr_b == '0) ? '0 : r_regs[i_raddr_b];

`ifdef ITYPE_DBG_PORT_EN
  assign o_rdata_dbg = (i_raddr_dbg == '0) ? '0 : r_regs[i_raddr_dbg];
`endif

endmodule

// File: rtl/itype_exec_unit.sv
// Single-cycle RV64 integer execute/write-back slice: decode, operand select,
// ALU control, ALU and register write-back. ITYPE_DBG_PORT_EN adds dbg_addr/dbg_data.
module itype_exec_unit
  import itype_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      alu_op,
  input  logic            reg_write,
  input  logic [31:0]     instr,
  output logic [XLEN-1:0] alu_result,
`ifdef ITYPE_DBG_PORT_EN
  input  logic [4:0]      dbg_addr,
  output logic [XLEN-1:0] dbg_data,
`endif
  output logic            zero
);

  logic [6:0]      w_opcode;
  logic [AW-1:0]   w_rd;
  logic [2:0]      w_funct3;
  logic [AW-1:0]   w_rs1;
  logic [AW-1:0]   w_rs2;
  logic            w_alt;
  logic [XLEN-1:0] w_rdata_a;
  logic [XLEN-1:0] w_rdata_b;
  logic [XLEN-1:0] w_op_a;
  logic [XLEN-1:0] w_op_b;
  logic [5:0]      w_shamt;
  alu_op_e         w_alu_op;
  alu_fn_e         w_fn;
  logic [XLEN-1:0] w_result;

  assign w_opcode = instr[6:0];
  assign w_rd     = instr[11:7];
  assign w_funct3 = instr[14:12];
  assign w_rs1    = instr[19:15];
  assign w_rs2    = instr[24:20];
  assign w_alt    = instr[30];
  assign w_alu_op = alu_op_e'(alu_op);

  itype_regfile u_regfile (
    .clk         (clk),
    .rst         (rst),
    .i_raddr_a   (w_rs1),
    .i_raddr_b   (w_rs2),
    .o_rdata_a   (w_rdata_a),
    .o_rdata_b   (w_rdata_b),
`ifdef ITYPE_DBG_PORT_EN
    .i_raddr_dbg (dbg_addr),
    .o_rdata_dbg (dbg_data),
`endif
    .i_we        (reg_write),
    .i_waddr     (w_rd),
    .i_wdata     (w_result)
  );

  assign w_op_a  = w_rdata_a;
  assign w_op_b  = uses_imm(w_opcode) ? sext_imm12(instr[31:20]) : w_rdata_b;
  assign w_shamt = w_op_b[5:0];

  // instr[30] selects sub only for register ops; for I-type it is an immediate bit.
  always_comb begin
    w_fn = FN_ADD;
    case (w_alu_op)
      ALUOP_ADD:  w_fn = FN_ADD;
      ALUOP_SUB:  w_fn = FN_SUB;
      ALUOP_RSVD: w_fn = FN_ADD;
      ALUOP_FUNCT: begin
        case (w_funct3)
          3'b000:  w_fn = (w_opcode == OP_REG && w_alt) ? FN_SUB : FN_ADD;
          3'b001:  w_fn = FN_SLL;
          3'b010:  w_fn = FN_SLT;
          3'b011:  w_fn = FN_SLTU;
          3'b100:  w_fn = FN_XOR;
          3'b101:  w_fn = w_alt ? FN_SRA : FN_SRL;
          3'b110:  w_fn = FN_OR;
          3'b111:  w_fn = FN_AND;
          default: w_fn = FN_ADD;
        endcase
      end
      default: w_fn = FN_ADD;
    endcase
  end

  always_comb begin
    w_result = '0;
    case (w_fn)
      FN_ADD:  w_result = w_op_a + w_op_b;
      FN_SUB:  w_result = w_op_a - w_op_b;
      FN_SLL:  w_result = w_op_a << w_shamt;
      FN_SLT:  w_result = XLEN'($signed(w_op_a) < $signed(w_op_b));
      FN_SLTU: w_result = XLEN'(w_op_a < w_op_b);
      FN_XOR:  w_result = w_op_a ^ w_op_b;
      FN_SRL:  w_result = w_op_a >> w_shamt;
      FN_SRA:  w_result = $unsigned($signed(w_op_a) >>> w_shamt);
      FN_OR:   w_result = w_op_a | w_op_b;
      FN_AND:  w_result = w_op_a & w_op_b;
      default: w_result = '0;
    endcase
  end

  assign alu_result = w_result;
  assign zero       = (w_result == '0);

endmodule

// File: tb/tb_itype_exec_unit.sv
// Directed self-checking bench for itype_exec_unit (default build).
module tb_itype_exec_unit;

  logic        clk;
  logic        rst;
  logic [1:0]  alu_op;
  logic        reg_write;
  logic [31:0] instr;
  logic [63:0] alu_result;
  logic        zero;

  int unsigned n_tests;
  int unsigned n_fail;

  itype_exec_unit dut (
    .clk        (clk),
    .rst        (rst),
    .alu_op     (alu_op),
    .reg_write  (reg_write),
    .instr      (instr),
    .alu_result (alu_result),
    .zero       (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [6:0] R_OP = 7'b0110011;
  localparam logic [6:0] I_OP = 7'b0010011;
  localparam logic [6:0] L_OP = 7'b0000011;
  localparam logic [6:0] U_OP = 7'b0110111;

  function automatic logic [31:0] rtype(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd, input logic [6:0] op);
    return {f7, rs2, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] itype(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  // Reads xN through the ALU as add x0,xN,x0 with writes disabled.
  task automatic read_reg(input logic [4:0] idx, output logic [63:0] val);
    @(negedge clk);
    rst       = 1'b0;
    reg_write = 1'b0;
    alu_op    = 2'b00;
    instr     = rtype(7'd0, 5'd0, idx, 3'd0, 5'd0, R_OP);
    #1;
    val = alu_result;
  endtask

  task automatic test_reset();
    logic [63:0] v;
    rst = 1'b1; instr = '0; alu_op = 2'b00; reg_write = 1'b1;
    @(posedge clk); #1;
    n_tests++;
    if (alu_result !== 64'd0) begin
      n_fail++; $display("FAIL reset_alu_result: got %h expected %h", alu_result, 64'd0);
    end
    n_tests++;
    if (zero !== 1'b1) begin
      n_fail++; $display("FAIL reset_zero: got %b expected %b", zero, 1'b1);
    end
    for (int i = 0; i < 32; i++) begin
      read_reg(5'(i), v);
      n_tests++;
      if (v !== 64'(i)) begin
        n_fail++; $display("FAIL reset_x%0d: got %h expected %h", i, v, 64'(i));
      end
    end
  endtask

  task automatic test_add();
    logic [63:0] v;
    @(negedge clk);
    instr = 32'h01F101B3; alu_op = 2'b10; reg_write = 1'b1;
    #1;
    n_tests++;
    if (alu_result !== 64'd33) begin
      n_fail++; $display("FAIL add_result: got %h expected %h", alu_result, 64'd33);
    end
    @(posedge clk);
    read_reg(5'd3, v);
    n_tests++;
    if (v !== 64'd33) begin
      n_fail++; $display("FAIL add_wb_x3: got %h expected %h", v, 64'd33);
    end
  endtask

  task automatic test_sub();
    logic [63:0] v;
    @(negedge clk);
    instr = 32'h41F101B3; alu_op = 2'b10; reg_write = 1'b1;
    #1;
    n_tests++;
    if (alu_result !== 64'hFFFF_FFFF_FFFF_FFE3) begin
      n_fail++; $display("FAIL sub_result: got %h expected %h", alu_result, 64'hFFFF_FFFF_FFFF_FFE3);
    end
    n_tests++;
    if (zero !== 1'b0) begin
      n_fail++; $display("FAIL sub_zero: got %b expected %b", zero, 1'b0);
    end
    @(posedge clk);
    read_reg(5'd3, v);
    n_tests++;
    if (v !== 64'hFFFF_FFFF_FFFF_FFE3) begin
      n_fail++; $display("FAIL sub_wb_x3: got %h expected %h", v, 64'hFFFF_FFFF_FFFF_FFE3);
    end
  endtask

  // x3 holds -29 here; exercises signed vs unsigned behaviour.
  task automatic test_negative_ops();
    logic [31:0] vi [4];
    logic [63:0] ve [4];
    vi[0] = itype(12'h402, 5'd3, 3'd5, 5'd0, I_OP); ve[0] = 64'hFFFF_FFFF_FFFF_FFF8;
    vi[1] = itype(12'h002, 5'd3, 3'd5, 5'd0, I_OP); ve[1] = 64'h3FFF_FFFF_FFFF_FFF8;
    vi[2] = rtype(7'd0, 5'd2, 5'd3, 3'd2, 5'd0, R_OP); ve[2] = 64'd1;
    vi[3] = rtype(7'd0, 5'd2, 5'd3, 3'd3, 5'd0, R_OP); ve[3] = 64'd0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      instr = vi[i]; alu_op = 2'b10; reg_write = 1'b0;
      #1;
      n_tests++;
      if (alu_result !== ve[i]) begin
        n_fail++; $display("FAIL neg_op%0d: got %h expected %h", i, alu_result, ve[i]);
      end
    end
  endtask

  task automatic test_addi_neg();
    logic [63:0] v;
    @(negedge clk);
    instr = 32'hFFF08293; alu_op = 2'b10; reg_write = 1'b1;
    #1;
    n_tests++;
    if (alu_result !== 64'd0) begin
      n_fail++; $display("FAIL addi_result: got %h expected %h", alu_result, 64'd0);
    end
    n_tests++;
    if (zero !== 1'b1) begin
      n_fail++; $display("FAIL addi_zero: got %b expected %b", zero, 1'b1);
    end
    @(posedge clk);
    read_reg(5'd5, v);
    n_tests++;
    if (v !== 64'd0) begin
      n_fail++; $display("FAIL addi_wb_x5: got %h expected %h", v, 64'd0);
    end
  endtask

  task automatic test_write_x0();
    logic [63:0] v;
    @(negedge clk);
    instr = 32'h01F10033; alu_op = 2'b10; reg_write = 1'b1;
    #1;
    n_tests++;
    if (alu_result !== 64'd33) begin
      n_fail++; $display("FAIL x0_result: got %h expected %h", alu_result, 64'd33);
    end
    @(posedge clk);
    read_reg(5'd0, v);
    n_tests++;
    if (v !== 64'd0) begin
      n_fail++; $display("FAIL x0_after_write: got %h expected %h", v, 64'd0);
    end
  endtask

  // Reset values apart from x3 = -29 and x5 = 0; none of these touch x3/x5.
  task automatic test_alu_ops();
    logic [31:0] vi [15];
    logic [1:0]  vo [15];
    logic [63:0] ve [15];
    vi[0]  = rtype(7'd0,  5'd2,  5'd6,  3'd1, 5'd0, R_OP); vo[0]  = 2'b10; ve[0]  = 64'd24;
    vi[1]  = rtype(7'd0,  5'd31, 5'd2,  3'd2, 5'd0, R_OP); vo[1]  = 2'b10; ve[1]  = 64'd1;
    vi[2]  = rtype(7'd0,  5'd2,  5'd31, 3'd2, 5'd0, R_OP); vo[2]  = 2'b10; ve[2]  = 64'd0;
    vi[3]  = itype(12'hFFF, 5'd1, 3'd2, 5'd0, I_OP);        vo[3]  = 2'b10; ve[3]  = 64'd0;
    vi[4]  = itype(12'hFFF, 5'd1, 3'd3, 5'd0, I_OP);        vo[4]  = 2'b10; ve[4]  = 64'd1;
    vi[5]  = rtype(7'd0,  5'd9,  5'd6,  3'd4, 5'd0, R_OP); vo[5]  = 2'b10; ve[5]  = 64'd15;
    vi[6]  = rtype(7'd0,  5'd2,  5'd31, 3'd5, 5'd0, R_OP); vo[6]  = 2'b10; ve[6]  = 64'd7;
    vi[7]  = rtype(7'h20, 5'd2,  5'd31, 3'd5, 5'd0, R_OP); vo[7]  = 2'b10; ve[7]  = 64'd7;
    vi[8]  = rtype(7'd0,  5'd2,  5'd9,  3'd6, 5'd0, R_OP); vo[8]  = 2'b10; ve[8]  = 64'd11;
    vi[9]  = rtype(7'd0,  5'd12, 5'd7,  3'd7, 5'd0, R_OP); vo[9]  = 2'b10; ve[9]  = 64'd4;
    vi[10] = itype(12'h03F, 5'd1, 3'd1, 5'd0, I_OP);        vo[10] = 2'b10; ve[10] = 64'h8000_0000_0000_0000;
    vi[11] = itype(12'h041, 5'd1, 3'd1, 5'd0, I_OP);        vo[11] = 2'b10; ve[11] = 64'd2;
    vi[12] = itype(12'h400, 5'd1, 3'd0, 5'd0, I_OP);        vo[12] = 2'b10; ve[12] = 64'd1025;
    vi[13] = rtype(7'd0,  5'd31, 5'd2,  3'd0, 5'd0, R_OP); vo[13] = 2'b01; ve[13] = 64'hFFFF_FFFF_FFFF_FFE3;
    vi[14] = 32'h41F101B3;                                  vo[14] = 2'b11; ve[14] = 64'd33;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      instr = vi[i]; alu_op = vo[i]; reg_write = 1'b0;
      #1;
      n_tests++;
      if (alu_result !== ve[i]) begin
        n_fail++; $display("FAIL alu_op%0d: got %h expected %h", i, alu_result, ve[i]);
      end
      n_tests++;
      if (zero !== (ve[i] == 64'd0)) begin
        n_fail++; $display("FAIL alu_zero%0d: got %b expected %b", i, zero, ve[i] == 64'd0);
      end
    end
    // Unknown opcode: register operand B, bit 30 does not select sub.
    @(negedge clk);
    instr = rtype(7'h20, 5'd31, 5'd2, 3'd0, 5'd0, U_OP); alu_op = 2'b10;
    #1;
    n_tests++;
    if (alu_result !== 64'd33) begin
      n_fail++; $display("FAIL unknown_opcode: got %h expected %h", alu_result, 64'd33);
    end
    @(negedge clk);
    instr = itype(12'hFF8, 5'd9, 3'd3, 5'd0, L_OP); alu_op = 2'b00;
    #1;
    n_tests++;
    if (alu_result !== 64'd1) begin
      n_fail++; $display("FAIL load_addr: got %h expected %h", alu_result, 64'd1);
    end
  endtask

  // addi x4,x4,1 repeated: each cycle sees the value written on the previous edge.
  task automatic test_back_to_back();
    logic [63:0] v;
    @(negedge clk);
    instr = itype(12'h001, 5'd4, 3'd0, 5'd4, I_OP); alu_op = 2'b10; reg_write = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_tests++;
      if (alu_result !== 64'(5 + i)) begin
        n_fail++; $display("FAIL b2b_cycle%0d: got %h expected %h", i, alu_result, 64'(5 + i));
      end
      @(posedge clk);
      @(negedge clk);
    end
    read_reg(5'd4, v);
    n_tests++;
    if (v !== 64'd8) begin
      n_fail++; $display("FAIL b2b_x4: got %h expected %h", v, 64'd8);
    end
  endtask

  task automatic test_write_gating();
    logic [63:0] v;
    @(negedge clk);
    rst = 1'b1; reg_write = 1'b0; instr = '0; alu_op = 2'b00;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0; instr = 32'h01F101B3; alu_op = 2'b10; reg_write = 1'b0;
    #1;
    n_tests++;
    if (alu_result !== 64'd33) begin
      n_fail++; $display("FAIL gate_result: got %h expected %h", alu_result, 64'd33);
    end
    @(posedge clk);
    read_reg(5'd3, v);
    n_tests++;
    if (v !== 64'd3) begin
      n_fail++; $display("FAIL gate_x3_no_write: got %h expected %h", v, 64'd3);
    end
    @(negedge clk);
    rst = 1'b1; reg_write = 1'b1; instr = 32'h01F101B3; alu_op = 2'b10;
    @(posedge clk);
    read_reg(5'd3, v);
    n_tests++;
    if (v !== 64'd3) begin
      n_fail++; $display("FAIL gate_rst_priority_x3: got %h expected %h", v, 64'd3);
    end
    read_reg(5'd4, v);
    n_tests++;
    if (v !== 64'd4) begin
      n_fail++; $display("FAIL gate_rst_x4: got %h expected %h", v, 64'd4);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_add();
    test_sub();
    test_negative_ops();
    test_addi_neg();
    test_write_x0();
    test_alu_ops();
    test_back_to_back();
    test_write_gating();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/itype_exec_unit.md
Name: itype_exec_unit

Overview:
- Single-cycle integer execute/write-back slice of the RV64 core.
- Decodes a 32-bit R-type (opcode 0110011) or I-type ALU/load-address (0010011 / 0000011) instruction and reads two operands from an internal 32x64 register file.
- Computes a 64-bit ALU result steered by the 2-bit main-control ALU op, and writes it back to rd on the clock edge.
- Sits between the main control decoder (supplies alu_op, reg_write) and the instruction fetch path (supplies instr).

Parameters:
- XLEN, 64, data/register width.
- NREGS, 32, number of architectural registers (index width 5).

Ports:
- clk  input  1  system clock, rising-edge active.
- rst  input  1  synchronous, active-high reset.
- alu_op  input  2  main-control ALU class: 00 add, 01 sub, 10 decode from funct3/funct7, 11 add.
- reg_write  input  1  write-back enable.
- instr  input  32  instruction word.
- alu_result  output  XLEN  combinational ALU output.
- zero  output  1  high when alu_result == 0.

Behaviour:
- One clock; reset is synchronous and active-high (clk, rst).
- Field decode:
  - opcode = instr[6:0], rd = instr[11:7], funct3 = instr[14:12], rs1 = instr[19:15], rs2 = instr[24:20], funct7 = instr[31:25].
- Operand select:
  - Operand A is always reg[rs1].
  - Operand B = sign-extended instr[31:20] when opcode is 0010011 or 0000011; otherwise reg[rs2].
- Register file reads: combinational, two ports. reg[0] always reads 0.
- ALU control:
  - alu_op 00 or 11: add.
  - alu_op 01: sub (A-B).
  - alu_op 10, by funct3:
    - 000: add; sub when opcode 0110011 and instr[30]=1.
    - 001: sll.
    - 010: slt (signed).
    - 011: sltu.
    - 100: xor.
    - 101: srl; sra when instr[30]=1.
    - 110: or.
    - 111: and.
- Shift amount is B[5:0]. slt/sltu produce 64-bit 0 or 1. All arithmetic is modulo 2^64, with no overflow flag.
- Write-back on rising clk:
  - If rst: reg[i] <= i for all i (x0 = 0), and no write occurs.
  - Else if reg_write and rd != 0: reg[rd] <= alu_result.
  - Writes to x0 are discarded.
- rst takes priority over reg_write when both are high.
- No bypass: a read of rd in the same cycle returns the old value; the new value is visible immediately after the edge.
- Outputs have no registers. After reset with instr = 0 the unit computes x0+x0, so alu_result = 0 and zero = 1.
- Unknown opcodes use the register operand B and follow alu_op normally.

Optional Feature:
- Macro: ITYPE_DBG_PORT_EN.
- When defined, two ports are added:
  - dbg_addr (input, 5): selects a register.
  - dbg_data (output, XLEN): combinational reg[dbg_addr]; dbg_addr = 0 returns 0.
- When not defined, these ports and their logic are absent, and register state is observable only through alu_result.
- Functional behaviour is otherwise identical.

Decomposition:
- Shared package itype_pkg holds:
  - XLEN and NREGS.
  - Opcode constants OP_REG = 7'b0110011, OP_IMM = 7'b0010011, OP_LOAD = 7'b0000011.
  - alu_op enum (ADD = 00, SUB = 01, FUNCT = 10, RSVD = 11).
  - Internal ALU function enum (ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND).
- One natural sub-module: itype_regfile (32x64, two combinational read ports, one synchronous write port, synchronous reset to index values, x0 hardwired to zero).
- ALU control and the ALU itself stay in the top module.

Test Plan:
- Reset: assert rst for one edge with instr = 0, alu_op = 00, reg_write = 1 -> every register holds its index (x0 = 0), alu_result = 0, zero = 1, and no write-back occurs.
- R-type add: instr = 0x01F101B3 (add x3,x2,x31), alu_op = 10, reg_write = 1 -> alu_result = 33 before the edge; x3 = 33 after the edge.
- R-type sub: instr = 0x41F101B3, alu_op = 10 -> alu_result = 0xFFFFFFFFFFFFFFE3 (-29), zero = 0; x3 holds this value after the edge.
- I-type addi with negative immediate: instr = 0xFFF08293 (addi x5,x1,-1), alu_op = 10 -> alu_result = 0, zero = 1; x5 = 0 after the edge.
- Write to x0: instr = 0x01F10033, alu_op = 10, reg_write = 1 -> alu_result = 33, but x0 still reads 0 after the edge.
- Write gating: repeat the 0x01F101B3 case from reset with reg_write = 0 -> x3 stays 3. Then assert rst and reg_write together -> x3 = 3 (reset wins).
